periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the peripheral request/ready bus (req / addr_ok / data_ok). Typical slaves are the GPIO, timer and UART register blocks.
- Lets the core data port (master 0) and the debug/loader port (master 1) share one peripheral slave port.
- Arbitration is round-robin. The grant is held from the address handshake until the slave's data_ok.
- A watchdog completes a stalled transfer with an error so a hung slave cannot lock up either master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MASK_W, 4, write byte-mask width (equals `RAM_MASK_WIDTH).
- TIMEOUT, 16, maximum cycles in BUSY before an error completion; legal range 2..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_req_i  in  1  master 0 request; held until m0_addr_ok_o.
- m0_we_i  in  1  master 0 write enable.
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_data_i  in  DATA_W  master 0 write data.
- m0_wem_i  in  MASK_W  master 0 byte mask.
- m0_addr_ok_o  out  1  master 0 request accepted.
- m0_data_ok_o  out  1  master 0 transfer complete; one-cycle pulse.
- m0_data_o  out  DATA_W  master 0 read data; valid with m0_data_ok_o.
- m0_err_o  out  1  master 0 timeout error; valid with m0_data_ok_o.
- m1_*  same nine signals as m0_* for master 1.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_data_o  out  DATA_W  slave write data.
- s_wem_o  out  MASK_W  slave byte mask.
- s_addr_ok_i  in  1  slave request accepted.
- s_data_ok_i  in  1  slave transfer complete.
- s_data_i  in  DATA_W  slave read data.
- busy_o  out  1  high while in BUSY.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE, owner=0, rr_prio=0 (master 0 preferred), timeout counter=0.
  - All registered outputs are 0: busy_o, m*_data_ok_o, m*_data_o, m*_err_o.
- IDLE:
  - Grant is combinational. If only one master requests, it is granted. If both request, the master given by rr_prio is granted.
  - s_req_o equals the granted master's req. s_we/addr/data/wem are muxed from the granted master. Non-granted masters get addr_ok=0.
  - The granted master's addr_ok = s_addr_ok_i, combinational and same cycle.
  - When s_req_o and s_addr_ok_i are both high: latch owner=grant, go to BUSY, clear the counter, set rr_prio = the other master.
  - With no request, s_req_o=0 and the slave mux selects master 0 fields. Outputs must not be X.
- BUSY:
  - s_req_o=0. Both m*_addr_ok_o=0. Slave address, data and control fields are held at the owner's values.
  - The counter increments each cycle.
  - If s_data_ok_i=1: in the next cycle the owner gets data_ok=1, data_o=s_data_i and err=0. State returns to IDLE.
  - Else if counter==TIMEOUT-1: in the next cycle the owner gets data_ok=1, data_o=0 and err=1. State returns to IDLE.
  - If s_data_ok_i and the timeout coincide, data_ok wins and err=0.
- Completion outputs:
  - m*_data_ok_o is registered: a pulse exactly one cycle wide, one cycle after the completing event.
  - m*_data_o and m*_err_o are 0 whenever the matching data_ok is 0.
  - The non-owner master never sees data_ok.
- Latency and throughput:
  - Latency with a GPIO-style slave (data_ok one cycle after accept): handshake cycle N, slave data_ok cycle N+1, master data_ok cycle N+2.
  - The next grant is possible in cycle N+2, the same cycle IDLE is re-entered.
- Stray slave data_ok in IDLE is ignored: no master data_ok.
- A late slave data_ok after a timeout arrives in IDLE and is ignored.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1...
- A master dropping req before addr_ok is a protocol violation. The arbiter simply re-arbitrates that cycle.
- Reset asserted mid-BUSY aborts the transfer with no data_ok; state returns to IDLE immediately.

Test Plan:
- Single read: m0 read addr 0x4, slave accepts same cycle, returns 0x0000_0003 one cycle later -> m0_data_ok_o pulses one cycle later with m0_data_o=0x3 and m0_err_o=0; m1 stays silent.
- Contention: m0 and m1 request continuously from reset, 4 transfers each -> slave sees owners 0,1,0,1,... and each master gets exactly 4 data_ok pulses.
- Write passthrough: m1 write addr 0x0, data 0x0000_0005, wem 0xF -> s_we_o=1, s_addr_o=0x0, s_data_o=0x5, s_wem_o=0xF in the handshake cycle; m1_data_ok_o follows with m1_data_o=0.
- Timeout: slave accepts m0 but never raises data_ok, TIMEOUT=16 -> m0_data_ok_o=1, m0_err_o=1, m0_data_o=0 sixteen cycles after the handshake cycle; a late s_data_ok_i afterwards produces no pulse.
- Coincident events: s_data_ok_i arrives on the timeout cycle with data 0xA5A5_A5A5 -> data_ok with data 0xA5A5_A5A5 and err=0.
- Reset mid-BUSY: rst_n is pulsed low one cycle after the handshake -> busy_o falls asynchronously, no m*_data_ok_o appears, and the next request after reset is granted to m0.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
//   Two-master / one-slave round-robin arbiter for the peripheral req/addr_ok/
//   data_ok bus. Master 0 is the core data port, master 1 the debug/loader port.
//   The winner owns the slave from its address handshake until the slave's
//   data_ok; a watchdog ends a stalled transfer with an error completion.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   m{0,1}_req/we/addr/data/wem_i   master request channel
//   m{0,1}_addr_ok_o           request accepted (combinational, same cycle)
//   m{0,1}_data_ok/data/err_o  registered one-cycle completion
//   s_req/we/addr/data/wem_o   slave request channel (muxed)
//   s_addr_ok_i, s_data_ok_i, s_data_i  slave responses
//   busy_o                     high while a transfer is outstanding
module periph_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic [MASK_W-1:0] m0_wem_i,
  output logic              m0_addr_ok_o,
  output logic              m0_data_ok_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic [MASK_W-1:0] m1_wem_i,
  output logic              m1_addr_ok_o,
  output logic              m1_data_ok_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_err_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic [MASK_W-1:0] s_wem_o,
  input  logic              s_addr_ok_i,
  input  logic              s_data_ok_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              busy_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner;
  logic       r_rr_prio;
  logic [7:0] r_cnt;

  logic w_grant;
  logic w_sel;
  logic w_sel_req;
  logic w_hs;
  logic w_timeout;
  logic w_done;

  // With no request the grant falls to master 0 so the slave mux never floats.
  assign w_grant   = (m0_req_i && m1_req_i) ? r_rr_prio : m1_req_i;
  assign w_sel     = (r_state == BUSY) ? r_owner : w_grant;
  assign w_sel_req = w_sel ? m1_req_i : m0_req_i;
  assign w_hs      = (r_state == IDLE) && w_sel_req && s_addr_ok_i;

  // r_cnt is 0 on the first BUSY cycle, so cycles elapsed since the handshake
  // are r_cnt+1; the error fires when that reaches TIMEOUT-1, giving the error
  // completion TIMEOUT cycles after the handshake.
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 2));
  assign w_done    = (r_state == BUSY) && (s_data_ok_i || w_timeout);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs)   w_state_nxt = BUSY;
      BUSY:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    s_req_o      = (r_state == IDLE) ? w_sel_req : 1'b0;
    s_we_o       = w_sel ? m1_we_i   : m0_we_i;
    s_addr_o     = w_sel ? m1_addr_i : m0_addr_i;
    s_data_o     = w_sel ? m1_data_i : m0_data_i;
    s_wem_o      = w_sel ? m1_wem_i  : m0_wem_i;
    m0_addr_ok_o = (r_state == IDLE) && !w_sel && m0_req_i && s_addr_ok_i;
    m1_addr_ok_o = (r_state == IDLE) &&  w_sel && m1_req_i && s_addr_ok_i;
    busy_o       = (r_state == BUSY);
  end

  // Ownership, fairness pointer and watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_rr_prio <= 1'b0;
      r_cnt     <= '0;
    end else if (w_hs) begin
      r_owner   <= w_grant;
      r_rr_prio <= ~w_grant;
      r_cnt     <= '0;
    end else if (r_state == BUSY) begin
      r_cnt     <= r_cnt + 8'd1;
    end
  end

  // Registered completion; slave data_ok beats a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_data_ok_o <= 1'b0;
      m0_data_o    <= '0;
      m0_err_o     <= 1'b0;
      m1_data_ok_o <= 1'b0;
      m1_data_o    <= '0;
      m1_err_o     <= 1'b0;
    end else begin
      m0_data_ok_o <= w_done && !r_owner;
      m0_data_o    <= (w_done && !r_owner && s_data_ok_i) ? s_data_i : '0;
      m0_err_o     <= w_done && !r_owner && !s_data_ok_i;
      m1_data_ok_o <= w_done && r_owner;
      m1_data_o    <= (w_done && r_owner && s_data_ok_i) ? s_data_i : '0;
      m1_err_o     <= w_done && r_owner && !s_data_ok_i;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
module tb_periph_bus_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0] m0_data_i, m1_data_i;
  logic [MASK_W-1:0] m0_wem_i, m1_wem_i;
  logic              m0_addr_ok_o, m0_data_ok_o, m0_err_o;
  logic              m1_addr_ok_o, m1_data_ok_o, m1_err_o;
  logic [DATA_W-1:0] m0_data_o, m1_data_o;
  logic              s_req_o, s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic [MASK_W-1:0] s_wem_o;
  logic              s_addr_ok_i, s_data_ok_i;
  logic [DATA_W-1:0] s_data_i;
  logic              busy_o;

  periph_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_wem_i(m0_wem_i), .m0_addr_ok_o(m0_addr_ok_o),
    .m0_data_ok_o(m0_data_ok_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_wem_i(m1_wem_i), .m1_addr_ok_o(m1_addr_ok_o),
    .m1_data_ok_o(m1_data_ok_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_wem_o(s_wem_o), .s_addr_ok_i(s_addr_ok_i), .s_data_ok_i(s_data_ok_i),
    .s_data_i(s_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0; m0_wem_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0; m1_wem_i = '0;
    s_addr_ok_i = 0; s_data_ok_i = 0; s_data_i = '0;
  endtask

  // Drive point: just after the rising edge; outputs are sampled #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1;
    logic        aok;
    logic        e_sreq, e_we;
    logic [31:0] e_addr;
    logic        e_ok0, e_ok1;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the random phase
  bit          m_idle, m_owner, m_prio;
  int          m_hs_cyc, sl_due;
  bit          pend[2], outst[2];
  logic        f_we[2];
  logic [31:0] f_addr[2], f_data[2];
  logic [3:0]  f_wem[2];
  logic        e_dok[2], e_err[2];
  logic [31:0] e_dat[2];

  initial begin
    do_reset();

    // ---- reset state (sampled while reset is asserted)
    set_idle();
    rst_n = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_dok0", m0_data_ok_o, 0);
    chk("rst_dok1", m1_data_ok_o, 0);
    chk("rst_dat0", m0_data_o, 0);
    chk("rst_err1", m1_err_o, 0);
    @(negedge clk);
    rst_n = 1;

    // ---- table: combinational IDLE grant with master 0 preferred
    vecs[0] = '{0,0,0,1, 32'h10, 32'h20, 1, 0,0, 32'h10, 0,0};
    vecs[1] = '{1,0,1,0, 32'h10, 32'h20, 1, 1,1, 32'h10, 1,0};
    vecs[2] = '{0,1,0,1, 32'h10, 32'h20, 1, 1,1, 32'h20, 0,1};
    vecs[3] = '{1,1,0,1, 32'h10, 32'h20, 1, 1,0, 32'h10, 1,0};
    vecs[4] = '{1,1,1,0, 32'h10, 32'h20, 0, 1,1, 32'h10, 0,0};
    vecs[5] = '{0,1,1,0, 32'h10, 32'h24, 0, 1,0, 32'h24, 0,0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m0_req_i = vecs[i].r0; m1_req_i = vecs[i].r1;
      m0_we_i = vecs[i].w0;  m1_we_i = vecs[i].w1;
      m0_addr_i = vecs[i].a0; m1_addr_i = vecs[i].a1;
      s_addr_ok_i = vecs[i].aok;
      #1;
      chk($sformatf("vec%0d_sreq", i), s_req_o, vecs[i].e_sreq);
      chk($sformatf("vec%0d_swe", i), s_we_o, vecs[i].e_we);
      chk($sformatf("vec%0d_saddr", i), s_addr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_aok0", i), m0_addr_ok_o, vecs[i].e_ok0);
      chk($sformatf("vec%0d_aok1", i), m1_addr_ok_o, vecs[i].e_ok1);
      set_idle();   // withdrawn before the next rising edge: no handshake
    end

    // ---- single read by m0
    cyc(); m0_req_i = 1; m0_addr_i = 32'h4; s_addr_ok_i = 1;
    #1; chk("rd_aok0", m0_addr_ok_o, 1); chk("rd_sreq", s_req_o, 1); chk("rd_saddr", s_addr_o, 32'h4);
    cyc(); set_idle(); s_data_ok_i = 1; s_data_i = 32'h3;
    #1; chk("rd_busy", busy_o, 1); chk("rd_dok_early", m0_data_ok_o, 0);
    cyc(); set_idle();
    #1; chk("rd_dok0", m0_data_ok_o, 1); chk("rd_dat0", m0_data_o, 32'h3);
    chk("rd_err0", m0_err_o, 0); chk("rd_dok1", m1_data_ok_o, 0); chk("rd_idle", busy_o, 0);
    cyc();
    #1; chk("rd_pulse_end", m0_data_ok_o, 0); chk("rd_dat_clr", m0_data_o, 0);

    // ---- write by m1
    cyc(); m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0; m1_data_i = 32'h5; m1_wem_i = 4'hF;
    s_addr_ok_i = 1;
    #1; chk("wr_swe", s_we_o, 1); chk("wr_saddr", s_addr_o, 0); chk("wr_sdata", s_data_o, 32'h5);
    chk("wr_swem", s_wem_o, 4'hF); chk("wr_aok1", m1_addr_ok_o, 1); chk("wr_aok0", m0_addr_ok_o, 0);
    cyc(); set_idle(); s_data_ok_i = 1;
    cyc(); set_idle();
    #1; chk("wr_dok1", m1_data_ok_o, 1); chk("wr_dat1", m1_data_o, 0);
    chk("wr_err1", m1_err_o, 0); chk("wr_dok0", m0_data_ok_o, 0);

    // ---- timeout on m0, then a late slave data_ok
    cyc(); m0_req_i = 1; m0_addr_i = 32'h8; s_addr_ok_i = 1;
    #1; chk("to_aok0", m0_addr_ok_o, 1);
    for (int i = 1; i <= 18; i++) begin
      cyc(); set_idle();
      if (i == 17) begin s_data_ok_i = 1; s_data_i = 32'h77; end
      #1;
      if (i == 15) begin chk("to_busy15", busy_o, 1); chk("to_dok15", m0_data_ok_o, 0); end
      if (i == 16) begin
        chk("to_dok", m0_data_ok_o, 1); chk("to_err", m0_err_o, 1);
        chk("to_dat", m0_data_o, 0); chk("to_idle", busy_o, 0);
      end
      if (i == 18) begin chk("late_dok0", m0_data_ok_o, 0); chk("late_dok1", m1_data_ok_o, 0); end
    end

    // ---- slave data_ok on the timeout cycle
    cyc(); m1_req_i = 1; s_addr_ok_i = 1;
    #1; chk("co_aok1", m1_addr_ok_o, 1);
    for (int i = 1; i <= 16; i++) begin
      cyc(); set_idle();
      if (i == 15) begin s_data_ok_i = 1; s_data_i = 32'hA5A5_A5A5; end
      #1;
      if (i == 16) begin
        chk("co_dok1", m1_data_ok_o, 1); chk("co_dat1", m1_data_o, 32'hA5A5_A5A5);
        chk("co_err1", m1_err_o, 0);
      end
    end

    // ---- reset during BUSY (m0 wins first so the pointer moves to m1)
    cyc(); m0_req_i = 1; s_addr_ok_i = 1;
    cyc(); set_idle();
    #1; chk("rb_busy", busy_o, 1);
    rst_n = 0;
    #1; chk("rb_busy_async", busy_o, 0);
    @(posedge clk); @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); set_idle(); s_data_ok_i = (i == 0);
      #1; chk("rb_no_dok0", m0_data_ok_o, 0); chk("rb_no_dok1", m1_data_ok_o, 0);
    end
    cyc(); m0_req_i = 1; m1_req_i = 1; s_addr_ok_i = 1;
    #1; chk("rb_grant0", m0_addr_ok_o, 1); chk("rb_nogrant1", m1_addr_ok_o, 0);
    cyc(); set_idle(); s_data_ok_i = 1;
    cyc(); set_idle();

    // ---- contention from reset: strict alternation
    do_reset();
    begin
      int hs_n = 0, d0 = 0, d1 = 0;
      bit prev_hs = 0;
      bit order[$];
      for (int c = 0; c < 30; c++) begin
        cyc();
        m0_req_i = (hs_n < 8); m1_req_i = (hs_n < 8);
        s_addr_ok_i = 1; s_data_ok_i = prev_hs; s_data_i = 32'(c);
        #1;
        if (m0_addr_ok_o) order.push_back(1'b0);
        if (m1_addr_ok_o) order.push_back(1'b1);
        prev_hs = m0_addr_ok_o | m1_addr_ok_o;
        if (prev_hs) hs_n++;
        if (m0_data_ok_o) d0++;
        if (m1_data_ok_o) d1++;
      end
      chk("fair_grants", order.size(), 8);
      foreach (order[i]) chk($sformatf("fair_owner%0d", i), order[i], i % 2);
      chk("fair_dok0", d0, 4);
      chk("fair_dok1", d1, 4);
    end

    // ---- randomized traffic against a transaction-level model
    do_reset();
    m_idle = 1; m_prio = 0; m_owner = 0; m_hs_cyc = 0; sl_due = -1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; outst[i] = 0; e_dok[i] = 0; e_err[i] = 0; e_dat[i] = '0;
    end
    for (int k = 0; k < 3000; k++) begin
      bit   r0, r1, g, sreq, hs, cmp, cmp_err;
      logic n_dok[2], n_err[2];
      logic [31:0] n_dat[2];
      cyc();
      for (int i = 0; i < 2; i++)
        if (!pend[i] && !outst[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1; f_we[i] = 1'($urandom); f_addr[i] = $urandom;
          f_data[i] = $urandom; f_wem[i] = 4'($urandom);
        end
      m0_req_i = pend[0]; m0_we_i = f_we[0]; m0_addr_i = f_addr[0];
      m0_data_i = f_data[0]; m0_wem_i = f_wem[0];
      m1_req_i = pend[1]; m1_we_i = f_we[1]; m1_addr_i = f_addr[1];
      m1_data_i = f_data[1]; m1_wem_i = f_wem[1];
      s_addr_ok_i = ($urandom_range(0, 99) < 60);
      s_data_ok_i = (k == sl_due) || (m_idle && $urandom_range(0, 99) < 10);
      s_data_i = $urandom;
      #1;
      chk("rnd_dok0", m0_data_ok_o, e_dok[0]); chk("rnd_dat0", m0_data_o, e_dat[0]);
      chk("rnd_err0", m0_err_o, e_err[0]);
      chk("rnd_dok1", m1_data_ok_o, e_dok[1]); chk("rnd_dat1", m1_data_o, e_dat[1]);
      chk("rnd_err1", m1_err_o, e_err[1]);
      chk("rnd_busy", busy_o, !m_idle);
      r0 = pend[0]; r1 = pend[1];
      g = (r0 && r1) ? m_prio : r1;
      sreq = m_idle && (r0 || r1);
      hs = sreq && s_addr_ok_i;
      chk("rnd_sreq", s_req_o, sreq);
      chk("rnd_aok0", m0_addr_ok_o, hs && !g);
      chk("rnd_aok1", m1_addr_ok_o, hs && g);
      if (hs) begin
        chk("rnd_saddr", s_addr_o, f_addr[g]); chk("rnd_swe", s_we_o, f_we[g]);
        chk("rnd_sdata", s_data_o, f_data[g]); chk("rnd_swem", s_wem_o, f_wem[g]);
      end
      n_dok = '{0, 0}; n_err = '{0, 0}; n_dat = '{0, 0};
      cmp = 0; cmp_err = 0;
      if (!m_idle) begin
        if (s_data_ok_i) cmp = 1;
        else if (k - m_hs_cyc == TIMEOUT - 1) begin cmp = 1; cmp_err = 1; end
      end
      if (cmp) begin
        n_dok[m_owner] = 1; n_err[m_owner] = cmp_err;
        n_dat[m_owner] = cmp_err ? 32'h0 : s_data_i;
        outst[m_owner] = 0; m_idle = 1;
      end
      if (hs) begin
        m_idle = 0; m_owner = g; m_prio = !g; m_hs_cyc = k;
        pend[g] = 0; outst[g] = 1;
        sl_due = k + int'($urandom_range(1, TIMEOUT + 4));
      end
      e_dok = n_dok; e_err = n_err; e_dat = n_dat;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
